// File: rtl/qea_host_loader_if.sv
// Stream bundle between the DMA/host side and qea_host_loader.
// The loader consumes the s_* stream and produces the m_* stream.
interface qea_host_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    s_valid;
    logic [2*DATA_WIDTH-1:0] s_data;
    logic                    s_ready;
    logic                    m_valid;
    logic [2*DATA_WIDTH-1:0] m_data;
    logic                    m_last;
    logic                    m_ready;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/qea_host_loader.sv
// Host-side initiator for the QEA accelerator: loads CTX and STATE RAMs from one
// input stream, starts the run, times it, and streams the final state vector back.
module qea_host_loader #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH               = 32
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]   i_ctx_num,

    qea_host_loader_if.slave                   bus,

    output logic                               o_ctx_en,
    output logic                               o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]            o_ctx_data,

    output logic                               o_state_ena,
    output logic                               o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_state_dina,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_state_dout,

    output logic                               o_start,
    input  logic                               i_complete,

    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_err,
    output logic [CNT_WIDTH-1:0]               o_exec_cycles
);

    localparam int BEAT_W    = 2 * DATA_WIDTH;
    localparam int ROW_W     = PE_NUM * BEAT_W;
    localparam int CTX_NUM_W = GATE_CONTEXT_ADDR_WIDTH + 1;
    localparam int ROWCNT_W  = STATE_ADDR_WIDTH + 1;

    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN  = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX  = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    localparam logic [CTX_NUM_W-1:0]      CTX_MAX   = CTX_NUM_W'(1) << GATE_CONTEXT_ADDR_WIDTH;
    localparam logic [PE_NUM_WIDTH-1:0]   BEAT_LAST = PE_NUM_WIDTH'(PE_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_CTX,
        S_LD_STATE,
        S_START,
        S_WAIT,
        S_RD_ISSUE,
        S_RD_STREAM,
        S_DONE
    } state_e;

    state_e                               state_q,    state_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_cnt_q,  ctx_cnt_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_last_q, ctx_last_d;
    logic [STATE_ADDR_WIDTH-1:0]          row_q,      row_d;
    logic [STATE_ADDR_WIDTH-1:0]          row_last_q, row_last_d;
    logic [PE_NUM_WIDTH-1:0]              beat_q,     beat_d;
    logic [ROW_W-1:0]                     row_buf_q,  row_buf_d;
    logic [ROW_W-1:0]                     rd_buf_q,   rd_buf_d;
    logic                                 rd_full_q,  rd_full_d;
    logic [CNT_WIDTH-1:0]                 exec_cnt_q, exec_cnt_d;

    logic                                 go_bad;
    logic [ROWCNT_W-1:0]                  rows_full;
    logic [ROW_W-1:0]                     packed_row;

    assign go_bad = (i_qbit_num < QBIT_MIN) || (i_qbit_num > QBIT_MAX) || (i_ctx_num > CTX_MAX);

    // ROWS = 2^(qbit_num - PE_NUM_WIDTH); only the last row index is kept.
    assign rows_full = ROWCNT_W'(1) << (i_qbit_num - QBIT_MIN);

    // New beats shift in at the bottom, so the first beat of a row ends up in the MSB slice.
    assign packed_row = {row_buf_q[ROW_W-BEAT_W-1:0], bus.s_data};

    assign bus.m_data    = rd_buf_q[ROW_W-1 -: BEAT_W];
    assign o_busy        = (state_q != S_IDLE);
    assign o_exec_cycles = exec_cnt_q;

    always_comb begin
        // NOTE: every _d and every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        ctx_cnt_d   = ctx_cnt_q;
        ctx_last_d  = ctx_last_q;
        row_d       = row_q;
        row_last_d  = row_last_q;
        beat_d      = beat_q;
        row_buf_d   = row_buf_q;
        rd_buf_d    = rd_buf_q;
        rd_full_d   = rd_full_q;
        exec_cnt_d  = exec_cnt_q;

        bus.s_ready   = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_last    = 1'b0;
        o_ctx_en      = 1'b0;
        o_ctx_wea     = 1'b0;
        o_ctx_addr    = '0;
        o_ctx_data    = '0;
        o_state_ena   = 1'b0;
        o_state_wea   = 1'b0;
        o_state_addra = '0;
        o_state_dina  = '0;
        o_start       = 1'b0;
        o_done        = 1'b0;
        o_err         = 1'b0;

        // A reset cycle suppresses every strobe and handshake immediately.
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_go) begin
                        if (go_bad) begin
                            o_err = 1'b1;
                        end else begin
                            ctx_cnt_d  = '0;
                            ctx_last_d = GATE_CONTEXT_ADDR_WIDTH'(i_ctx_num - CTX_NUM_W'(1));
                            row_d      = '0;
                            row_last_d = STATE_ADDR_WIDTH'(rows_full - ROWCNT_W'(1));
                            beat_d     = '0;
                            state_d    = (i_ctx_num == '0) ? S_LD_STATE : S_LD_CTX;
                        end
                    end
                end

                S_LD_CTX: begin
                    bus.s_ready = 1'b1;
                    if (bus.s_valid) begin
                        o_ctx_en   = 1'b1;
                        o_ctx_wea  = 1'b1;
                        o_ctx_addr = ctx_cnt_q;
                        o_ctx_data = bus.s_data;
                        if (ctx_cnt_q == ctx_last_q) begin
                            ctx_cnt_d = '0;
                            state_d   = S_LD_STATE;
                        end else begin
                            ctx_cnt_d = ctx_cnt_q + 1'b1;
                        end
                    end
                end

                S_LD_STATE: begin
                    bus.s_ready = 1'b1;
                    if (bus.s_valid) begin
                        row_buf_d = packed_row;
                        if (beat_q == BEAT_LAST) begin
                            o_state_ena   = 1'b1;
                            o_state_wea   = 1'b1;
                            o_state_addra = row_q;
                            o_state_dina  = packed_row;
                            beat_d        = '0;
                            if (row_q == row_last_q) begin
                                row_d   = '0;
                                state_d = S_START;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end

                S_START: begin
                    o_start    = 1'b1;
                    exec_cnt_d = '0;
                    state_d    = S_WAIT;
                end

                // The cycle that sees i_complete is counted too, so an immediate completion reads 1.
                S_WAIT: begin
                    exec_cnt_d = exec_cnt_q + 1'b1;
                    if (i_complete) begin
                        state_d = S_RD_ISSUE;
                    end
                end

                S_RD_ISSUE: begin
                    o_state_ena   = 1'b1;
                    o_state_addra = row_q;
                    rd_full_d     = 1'b0;
                    state_d       = S_RD_STREAM;
                end

                S_RD_STREAM: begin
                    if (!rd_full_q) begin
                        rd_buf_d  = i_state_dout;
                        rd_full_d = 1'b1;
                    end else begin
                        bus.m_valid = 1'b1;
                        bus.m_last  = (beat_q == BEAT_LAST) && (row_q == row_last_q);
                        if (bus.m_ready) begin
                            rd_buf_d = rd_buf_q << BEAT_W;
                            if (beat_q == BEAT_LAST) begin
                                beat_d    = '0;
                                rd_full_d = 1'b0;
                                if (row_q == row_last_q) begin
                                    row_d   = '0;
                                    state_d = S_DONE;
                                end else begin
                                    row_d   = row_q + 1'b1;
                                    state_d = S_RD_ISSUE;
                                end
                            end else begin
                                beat_d = beat_q + 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctx_cnt_q  <= '0;
            ctx_last_q <= '0;
            row_q      <= '0;
            row_last_q <= '0;
            beat_q     <= '0;
            // NOTE: the row buffers are reset as well, because m_data is taken straight from rd_buf_q and must read 0 after reset.
            row_buf_q  <= '0;
            rd_buf_q   <= '0;
            rd_full_q  <= 1'b0;
            exec_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ctx_cnt_q  <= ctx_cnt_d;
            ctx_last_q <= ctx_last_d;
            row_q      <= row_d;
            row_last_q <= row_last_d;
            beat_q     <= beat_d;
            row_buf_q  <= row_buf_d;
            rd_buf_q   <= rd_buf_d;
            rd_full_q  <= rd_full_d;
            exec_cnt_q <= exec_cnt_d;
        end
    end

endmodule

// File: tb/tb_qea_host_loader.sv
// Self-checking bench for qea_host_loader: scoreboarded load/run/readback jobs,
// a table of i_go vectors, and a mid-load reset sequence.
module tb_qea_host_loader;

    logic         clk;
    logic         rst;
    logic         i_go;
    logic [5:0]   i_qbit_num;
    logic [16:0]  i_ctx_num;
    logic         o_ctx_en, o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic         o_state_ena, o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic [255:0] i_state_dout;
    logic         o_start, i_complete;
    logic         o_busy, o_done, o_err;
    logic [31:0]  o_exec_cycles;

    qea_host_loader_if #(.DATA_WIDTH(32)) bus ();

    qea_host_loader dut (
        .clk           (clk),
        .rst           (rst),
        .i_go          (i_go),
        .i_qbit_num    (i_qbit_num),
        .i_ctx_num     (i_ctx_num),
        .bus           (bus),
        .o_ctx_en      (o_ctx_en),
        .o_ctx_wea     (o_ctx_wea),
        .o_ctx_addr    (o_ctx_addr),
        .o_ctx_data    (o_ctx_data),
        .o_state_ena   (o_state_ena),
        .o_state_wea   (o_state_wea),
        .o_state_addra (o_state_addra),
        .o_state_dina  (o_state_dina),
        .i_state_dout  (i_state_dout),
        .o_start       (o_start),
        .i_complete    (i_complete),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_exec_cycles (o_exec_cycles)
    );

    typedef struct packed { logic [15:0] addr; logic [63:0]  data; } ctx_exp_t;
    typedef struct packed { logic [15:0] addr; logic [255:0] row;  } row_exp_t;
    typedef struct packed { logic [63:0] data; logic         last; } beat_exp_t;

    typedef struct {
        string       name;
        logic [5:0]  qbit;
        logic [16:0] ctx;
        logic        exp_err;
    } go_vec_t;

    ctx_exp_t  ctx_q[$];
    row_exp_t  row_q[$];
    beat_exp_t beat_q[$];

    int total, bad;
    int cyc;
    int done_cnt, start_cnt, beats_rx;
    int done_cyc, last_cyc;
    int exec_delay;
    int cur_rows;
    bit ready_rand;
    bit rd_phase;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every RAM strobe and output beat is matched against the queues.
    always @(negedge clk) begin : monitor
        ctx_exp_t  ce;
        row_exp_t  re;
        beat_exp_t be;
        static bit          prev_stall = 1'b0;
        static logic [63:0] prev_data  = '0;
        static logic        prev_last  = 1'b0;

        if (o_ctx_en) begin
            if (ctx_q.size() == 0) begin
                check("ctx_extra_strobe", o_ctx_en, 1'b0);
            end else begin
                ce = ctx_q.pop_front();
                check("ctx_wea", o_ctx_wea, 1'b1);
                check("ctx_addr", o_ctx_addr, ce.addr);
                check("ctx_data", o_ctx_data, ce.data);
            end
        end

        if (o_state_ena && rd_phase) begin
            check("wea_in_readback", o_state_wea, 1'b0);
        end else if (o_state_ena && o_state_wea) begin
            if (row_q.size() == 0) begin
                check("row_extra_strobe", o_state_wea, 1'b0);
            end else begin
                re = row_q.pop_front();
                check("row_addr", o_state_addra, re.addr);
                check("row_data", o_state_dina, re.row);
            end
        end
        if (o_state_ena && !o_state_wea) rd_phase = 1'b1;

        if (prev_stall) begin
            check("stall_valid", bus.m_valid, 1'b1);
            check("stall_data", bus.m_data, prev_data);
            check("stall_last", bus.m_last, prev_last);
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;

        if (bus.m_valid && bus.m_ready) begin
            if (beat_q.size() == 0) begin
                check("beat_extra", bus.m_valid, 1'b0);
            end else begin
                be = beat_q.pop_front();
                check("beat_data", bus.m_data, be.data);
                check("beat_last", bus.m_last, be.last);
            end
            beats_rx++;
            if (bus.m_last) last_cyc = cyc;
        end

        if (o_start) start_cnt++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            rd_phase = 1'b0;
        end
    end

    // STATE RAM read model: row r reads back as {r, r+1, r+2, r+3}, one cycle after the read strobe.
    initial begin : ram_model
        int        a;
        beat_exp_t be;
        i_state_dout = '0;
        forever begin
            @(negedge clk);
            if (o_state_ena && !o_state_wea) begin
                a = int'(o_state_addra);
                for (int j = 0; j < 4; j++) begin
                    be.data = 64'(a + j);
                    be.last = (a == cur_rows - 1) && (j == 3);
                    beat_q.push_back(be);
                end
                @(posedge clk);
                #1;
                i_state_dout = {64'(a), 64'(a + 1), 64'(a + 2), 64'(a + 3)};
            end
        end
    end

    // Accelerator model: completion rises exec_delay cycles after the start pulse.
    initial begin : qea_model
        i_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (o_start) begin
                i_complete = 1'b0;
                repeat (exec_delay) @(posedge clk);
                #1;
                i_complete = 1'b1;
            end
        end
    end

    initial begin : sink_ready
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic send_word(input logic [63:0] w);
        bit ok;
        ok = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus.s_ready;
        end
        if (!ok) check("s_ready_timeout", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_s_ready", tag),     bus.s_ready,   '0);
        check($sformatf("%s_m_valid", tag),     bus.m_valid,   '0);
        check($sformatf("%s_m_data", tag),      bus.m_data,    '0);
        check($sformatf("%s_m_last", tag),      bus.m_last,    '0);
        check($sformatf("%s_ctx_en", tag),      o_ctx_en,      '0);
        check($sformatf("%s_ctx_wea", tag),     o_ctx_wea,     '0);
        check($sformatf("%s_ctx_addr", tag),    o_ctx_addr,    '0);
        check($sformatf("%s_ctx_data", tag),    o_ctx_data,    '0);
        check($sformatf("%s_state_ena", tag),   o_state_ena,   '0);
        check($sformatf("%s_state_wea", tag),   o_state_wea,   '0);
        check($sformatf("%s_state_addra", tag), o_state_addra, '0);
        check($sformatf("%s_state_dina", tag),  o_state_dina,  '0);
        check($sformatf("%s_start", tag),       o_start,       '0);
        check($sformatf("%s_busy", tag),        o_busy,        '0);
        check($sformatf("%s_done", tag),        o_done,        '0);
        check($sformatf("%s_err", tag),         o_err,         '0);
        check($sformatf("%s_exec_cycles", tag), o_exec_cycles, '0);
    endtask

    task automatic drive_go(input int qb, input int ctx);
        @(posedge clk);
        #1;
        i_qbit_num = 6'(qb);
        i_ctx_num  = 17'(ctx);
        i_go       = 1'b1;
        @(posedge clk);
        #1;
        i_go = 1'b0;
    endtask

    task automatic run_job(input int qb, input int ctx, input int delay, input bit big, input bit rnd);
        int          rows, d0, s0, b0, t;
        logic [255:0] acc;
        logic [63:0]  w;
        ctx_exp_t     ce;
        row_exp_t     re;
        rows       = 1 << (qb - 2);
        cur_rows   = rows;
        exec_delay = delay;
        ready_rand = rnd;
        d0 = done_cnt;
        s0 = start_cnt;
        b0 = beats_rx;
        drive_go(qb, ctx);
        for (int k = 0; k < ctx; k++) begin
            w       = {16'hC7C7, 16'(k), 32'($urandom)};
            ce.addr = 16'(k);
            ce.data = w;
            ctx_q.push_back(ce);
            send_word(w);
        end
        acc = '0;
        for (int i = 0; i < rows * 4; i++) begin
            if (big) w = (i == 0) ? 64'h40000000_00000000 : 64'h0;
            else     w = {$urandom, $urandom};
            acc = {acc[191:0], w};
            if (i % 4 == 3) begin
                re.addr = 16'(i / 4);
                re.row  = acc;
                row_q.push_back(re);
            end
            send_word(w);
        end
        bus.s_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < rows * 40 + delay + 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check($sformatf("q%0d_done_pulses", qb),     done_cnt - d0, 1);
        check($sformatf("q%0d_start_pulses", qb),    start_cnt - s0, 1);
        check($sformatf("q%0d_exec_cycles", qb),     o_exec_cycles, delay);
        check($sformatf("q%0d_beats_rx", qb),        beats_rx - b0, rows * 4);
        check($sformatf("q%0d_done_after_last", qb), done_cyc - last_cyc, 1);
        check($sformatf("q%0d_queues_empty", qb),    ctx_q.size() + row_q.size() + beat_q.size(), 0);
        @(negedge clk);
        check($sformatf("q%0d_idle_after_done", qb), o_busy, 1'b0);
        check($sformatf("q%0d_exec_hold", qb),       o_exec_cycles, delay);
    endtask

    initial begin : main
        go_vec_t vecs[7];
        vecs[0] = '{"qbit_too_small", 6'd1,  17'd10,    1'b1};
        vecs[1] = '{"ctx_too_big",    6'd2,  17'd65537, 1'b1};
        vecs[2] = '{"qbit_too_big",   6'd19, 17'd4,     1'b1};
        vecs[3] = '{"qbit_zero",      6'd0,  17'd0,     1'b1};
        vecs[4] = '{"ctx_max_ok",     6'd2,  17'd65536, 1'b0};
        vecs[5] = '{"qbit_max_ok",    6'd18, 17'd0,     1'b0};
        vecs[6] = '{"typical_ok",     6'd13, 17'd1,     1'b0};

        total = 0; bad = 0; cyc = 0;
        done_cnt = 0; start_cnt = 0; beats_rx = 0;
        done_cyc = 0; last_cyc = 0;
        exec_delay = 1; cur_rows = 1; ready_rand = 1'b0; rd_phase = 1'b0;
        rst = 1'b1; i_go = 1'b0; i_qbit_num = '0; i_ctx_num = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Full-size job: 13 qubits, 1363 context words, 500-cycle execution, random back-pressure.
        run_job(13, 1363, 500, 1'b1, 1'b1);

        for (int v = 0; v < 7; v++) begin
            @(posedge clk);
            #1;
            i_qbit_num = vecs[v].qbit;
            i_ctx_num  = vecs[v].ctx;
            i_go       = 1'b1;
            @(negedge clk);
            check({vecs[v].name, "_err"},       o_err, vecs[v].exp_err);
            check({vecs[v].name, "_ready_go"},  bus.s_ready, 1'b0);
            @(posedge clk);
            #1;
            i_go = 1'b0;
            @(negedge clk);
            check({vecs[v].name, "_busy"},      o_busy, !vecs[v].exp_err);
            check({vecs[v].name, "_err_pulse"}, o_err, 1'b0);
            check({vecs[v].name, "_ready"},     bus.s_ready, !vecs[v].exp_err);
            if (!vecs[v].exp_err) begin
                @(posedge clk);
                #1;
                i_qbit_num = 6'd1;
                i_go       = 1'b1;
                @(negedge clk);
                check({vecs[v].name, "_go_ignored_busy"}, o_err, 1'b0);
                @(posedge clk);
                #1;
                i_go = 1'b0;
                rst  = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end

        // Reset in the middle of LD_STATE: one row written, one beat of the next row held.
        begin : mid_reset
            ctx_exp_t     ce;
            row_exp_t     re;
            logic [255:0] acc;
            logic [63:0]  w;
            cur_rows = 4;
            drive_go(4, 2);
            for (int k = 0; k < 2; k++) begin
                w       = {32'hABCD0000 + 32'(k), 32'($urandom)};
                ce.addr = 16'(k);
                ce.data = w;
                ctx_q.push_back(ce);
                send_word(w);
            end
            acc = '0;
            for (int i = 0; i < 5; i++) begin
                w   = {$urandom, $urandom};
                acc = {acc[191:0], w};
                if (i == 3) begin
                    re.addr = 16'd0;
                    re.row  = acc;
                    row_q.push_back(re);
                end
                send_word(w);
            end
            bus.s_data = 64'hDEAD_BEEF_0BAD_F00D;
            rst = 1'b1;
            @(negedge clk);
            check("rst_cycle_s_ready", bus.s_ready, 1'b0);
            @(posedge clk);
            #1;
            rst         = 1'b0;
            bus.s_valid = 1'b0;
            @(negedge clk);
            check_all_zero("rst_mid");
            check("rst_mid_queues_empty", ctx_q.size() + row_q.size(), 0);
        end

        // Fresh jobs after the abort: addresses restart at 0; ctx_num = 0 and immediate completion corners.
        run_job(3, 3, 1, 1'b0, 1'b1);
        run_job(2, 0, 3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
